// File: rtl/uhc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uhc_ctrl
// Brief    : Prescaled 4-bit up counter with wrap/saturate terminal handling.
// Revision : 1.0 - initial release
// ============================================================================
module uhc_ctrl #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       uhc_clk,
  input  logic       uhc_rst_n,
  input  logic       uhc_en,
  input  logic       uhc_load,
  input  logic [3:0] uhc_d,
  input  logic [3:0] uhc_max,
  input  logic       uhc_mode,
  output logic [3:0] uhc_q,
  output logic       uhc_tick,
  output logic       uhc_carry,
  output logic       uhc_done
);

  localparam int unsigned     PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  localparam logic [0:0] ST_COUNT = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic             w_tick_cond;
  logic             w_at_term;
  logic             w_count_step;

  assign w_tick_cond  = uhc_en && (pre_q == PRE_LAST);
  assign w_at_term    = (cnt_q >= uhc_max);
  // Ticks that arrive while saturated are still generated but never move the count.
  assign w_count_step = w_tick_cond && !uhc_load && (state_q == ST_COUNT);

  // State register
  always_ff @(posedge uhc_clk or negedge uhc_rst_n) begin
    if (!uhc_rst_n) begin
      state_q <= ST_COUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (uhc_load) begin
      state_d = ST_COUNT;
    end else if (w_count_step && w_at_term && uhc_mode) begin
      state_d = ST_DONE;
    end
  end

  // Datapath / output next-value logic
  always_comb begin
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    tick_d  = w_tick_cond && !uhc_load;

    if (uhc_load) begin
      pre_d = '0;
    end else if (uhc_en) begin
      pre_d = w_tick_cond ? '0 : pre_q + PRE_W'(1);
    end

    if (uhc_load) begin
      cnt_d = (uhc_d > uhc_max) ? uhc_max : uhc_d;
    end else if (w_count_step) begin
      if (!w_at_term) begin
        cnt_d = cnt_q + 4'd1;
      end else if (!uhc_mode) begin
        cnt_d   = 4'd0;
        carry_d = 1'b1;
      end else begin
        cnt_d = uhc_max;
      end
    end

    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge uhc_clk or negedge uhc_rst_n) begin
    if (!uhc_rst_n) begin
      pre_q   <= '0;
      cnt_q   <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign uhc_q     = cnt_q;
  assign uhc_tick  = tick_q;
  assign uhc_carry = carry_q;
  assign uhc_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uhc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uhc_ctrl
// Brief    : Scoreboard bench for uhc_ctrl with DIV=4 and directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uhc_ctrl;

  logic       uhc_clk;
  logic       uhc_rst_n;
  logic       uhc_en;
  logic       uhc_load;
  logic [3:0] uhc_d;
  logic [3:0] uhc_max;
  logic       uhc_mode;
  logic [3:0] uhc_q;
  logic       uhc_tick;
  logic       uhc_carry;
  logic       uhc_done;

  uhc_ctrl #(.DIV(4)) dut (
    .uhc_clk  (uhc_clk),
    .uhc_rst_n(uhc_rst_n),
    .uhc_en   (uhc_en),
    .uhc_load (uhc_load),
    .uhc_d    (uhc_d),
    .uhc_max  (uhc_max),
    .uhc_mode (uhc_mode),
    .uhc_q    (uhc_q),
    .uhc_tick (uhc_tick),
    .uhc_carry(uhc_carry),
    .uhc_done (uhc_done)
  );

  typedef struct packed {
    logic [3:0]  q;
    logic        carry;
    logic        done;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc    = 0;
  logic [31:0] base;

  initial uhc_clk = 1'b0;
  always #5 uhc_clk = ~uhc_clk;

  always @(posedge uhc_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] q, input logic c, input logic d, input logic [31:0] at);
    exp_t e;
    e.q = q; e.carry = c; e.done = d; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge uhc_clk);
    #1;
  endtask

  // Monitor: every presented tick is matched against the next expected event.
  always @(negedge uhc_clk) begin
    if (uhc_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick cyc=%0d q=%0d carry=%0d done=%0d", cyc, uhc_q, uhc_carry, uhc_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (uhc_q !== e.q || uhc_carry !== e.carry || uhc_done !== e.done || cyc !== e.cyc) begin
          errors++;
          $display("FAIL tick_event actual cyc=%0d q=%0d carry=%0d done=%0d expected cyc=%0d q=%0d carry=%0d done=%0d",
                   cyc, uhc_q, uhc_carry, uhc_done, e.cyc, e.q, e.carry, e.done);
        end
      end
    end else if (uhc_carry) begin
      checks++;
      errors++;
      $display("FAIL carry_without_tick cyc=%0d carry=%0d expected=0", cyc, uhc_carry);
    end
  end

  initial begin
    uhc_rst_n = 1'b0;
    uhc_en    = 1'b0;
    uhc_load  = 1'b0;
    uhc_d     = 4'd0;
    uhc_max   = 4'd15;
    uhc_mode  = 1'b0;

    #12;
    chk("reset_q",     uhc_q,     0);
    chk("reset_tick",  uhc_tick,  0);
    chk("reset_carry", uhc_carry, 0);
    chk("reset_done",  uhc_done,  0);
    step();
    uhc_rst_n = 1'b1;

    // Full wrap over 64 enabled cycles
    uhc_en = 1'b1; uhc_max = 4'd15; uhc_mode = 1'b0;
    base = cyc;
    for (int i = 1; i <= 16; i++) push(4'(i % 16), (i == 16), 1'b0, base + 32'(4 * i));
    repeat (64) step();
    uhc_en = 1'b0;

    // Saturate at 5, mode change while saturated must not leave DONE
    uhc_en = 1'b1; uhc_max = 4'd5; uhc_mode = 1'b1;
    base = cyc;
    for (int i = 1; i <= 16; i++) push((i <= 5) ? 4'(i) : 4'd5, 1'b0, (i >= 6), base + 32'(4 * i));
    repeat (32) step();
    uhc_mode = 1'b0;
    repeat (32) step();
    uhc_en = 1'b0;
    chk("done_held", uhc_done, 1);

    // Load 3, then enable toggled every cycle
    uhc_load = 1'b1; uhc_d = 4'd3; uhc_max = 4'd15;
    step();
    uhc_load = 1'b0;
    chk("load3_q",    uhc_q,    3);
    chk("load3_done", uhc_done, 0);
    chk("load3_tick", uhc_tick, 0);
    base = cyc;
    push(4'd4, 1'b0, 1'b0, base + 7);
    push(4'd5, 1'b0, 1'b0, base + 15);
    for (int i = 0; i < 16; i++) begin
      uhc_en = (i % 2 == 0);
      step();
    end
    uhc_en = 1'b0;

    // Load coinciding with tick condition, clamped to max
    uhc_en = 1'b1;
    repeat (3) step();
    uhc_load = 1'b1; uhc_d = 4'd12; uhc_max = 4'd9;
    step();
    uhc_load = 1'b0;
    chk("loadclamp_q",     uhc_q,     9);
    chk("loadclamp_tick",  uhc_tick,  0);
    chk("loadclamp_carry", uhc_carry, 0);
    base = cyc;
    push(4'd0, 1'b1, 1'b0, base + 4);
    repeat (4) step();
    uhc_en = 1'b0;

    // Reach DONE at 7, leave prescaler part-way, then async reset pulse
    uhc_load = 1'b1; uhc_d = 4'd7; uhc_max = 4'd7; uhc_mode = 1'b1;
    step();
    uhc_load = 1'b0;
    chk("load7_q", uhc_q, 7);
    uhc_en = 1'b1;
    base = cyc;
    push(4'd7, 1'b0, 1'b1, base + 4);
    repeat (6) step();
    uhc_en = 1'b0;
    chk("done7_done", uhc_done, 1);
    #2 uhc_rst_n = 1'b0;
    #1;
    chk("async_rst_q",    uhc_q,    0);
    chk("async_rst_done", uhc_done, 0);
    uhc_rst_n = 1'b1;
    uhc_max = 4'd15; uhc_mode = 1'b0; uhc_en = 1'b1;
    base = cyc;
    push(4'd1, 1'b0, 1'b0, base + 4);
    push(4'd2, 1'b0, 1'b0, base + 8);
    repeat (8) step();
    uhc_en = 1'b0;

    // Terminal of zero in wrap mode: carry on every tick
    uhc_max = 4'd0; uhc_mode = 1'b0; uhc_en = 1'b1;
    base = cyc;
    for (int i = 1; i <= 4; i++) push(4'd0, 1'b1, 1'b0, base + 32'(4 * i));
    repeat (16) step();
    uhc_en = 1'b0;
    chk("max0_q", uhc_q, 0);
    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
